// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
// Holds the queue geometry, the PC width, the nop encoding, the entry
// layout and a pointer-increment helper used by fetch_queue.
package fetch_pkg;

    localparam int PC_W     = 32;
    localparam int FQ_DEPTH = 4;
    localparam int FQ_PTR_W = 2;
    localparam int FQ_CNT_W = 3;

    localparam logic [PC_W-1:0] NOP_IR = 32'b0;

    // One queue slot: the fetch address and the word returned for it.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] ir;
    } fq_entry_t;

    // Pointers are exactly FQ_PTR_W bits wide, so 3 + 1 wraps to 0.
    function automatic logic [FQ_PTR_W-1:0] ptr_inc(input logic [FQ_PTR_W-1:0] p);
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/fq_entry_array.sv
// Storage for the fetch queue: FQ_DEPTH entries of {pc, ir}.
// Ports:
//   clock - write clock
//   we    - write enable
//   waddr - write slot
//   wdata - entry to write
//   raddr - read slot
//   rdata - combinational read of slot raddr
// The storage is deliberately not reset; occupancy lives in fetch_queue.
module fq_entry_array
    import fetch_pkg::*;
(
    input  logic                clock,
    input  logic                we,
    input  logic [FQ_PTR_W-1:0] waddr,
    input  fq_entry_t           wdata,
    input  logic [FQ_PTR_W-1:0] raddr,
    output fq_entry_t           rdata
);

    fq_entry_t mem_r [FQ_DEPTH];

    // Single write port.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches one word per cycle from imem into a
// 4-entry circular FIFO and presents the head to decode.
// Ports:
//   clock, reset  - clock and asynchronous active-high reset
//   address_imem  - fetch PC presented to imem
//   q_imem        - instruction word for address_imem, same cycle
//   redirect      - flush the queue and restart fetch at redirect_pc
//   redirect_pc   - new fetch PC
//   stall         - decode not accepting; head is held
//   fq_valid      - head entry present
//   fq_ir, fq_pc  - head instruction and its PC (zero when not valid)
//   fq_count      - occupancy 0..4
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty the imem word
// is presented to decode in the same cycle, and is not stored if consumed.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    output logic [PC_W-1:0]     address_imem,
    input  logic [PC_W-1:0]     q_imem,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    input  logic                stall,
    output logic                fq_valid,
    output logic [PC_W-1:0]     fq_ir,
    output logic [PC_W-1:0]     fq_pc,
    output logic [FQ_CNT_W-1:0] fq_count
);

    logic [PC_W-1:0]     fetch_pc_r;
    logic [FQ_CNT_W-1:0] count_r;
    logic [FQ_PTR_W-1:0] rd_ptr_r;
    logic [FQ_PTR_W-1:0] wr_ptr_r;

    fq_entry_t head_s;
    fq_entry_t wdata_s;
    logic      bypass_s;
    logic      pop_s;
    logic      push_s;
    logic      store_s;
    logic      deq_s;

    assign wdata_s = '{pc: fetch_pc_r, ir: q_imem};

    fq_entry_array u_array (
        .clock (clock),
        .we    (store_s),
        .waddr (wr_ptr_r),
        .wdata (wdata_s),
        .raddr (rd_ptr_r),
        .rdata (head_s)
    );

    // Head presentation and push/pop decisions.
    always_comb begin
        bypass_s = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if ((count_r == '0) && !redirect && !reset) begin
            bypass_s = 1'b1;
        end else begin
            bypass_s = 1'b0;
        end
`else
        bypass_s = 1'b0;
`endif
        if (count_r != '0) begin
            fq_valid = 1'b1;
            fq_ir    = head_s.ir;
            fq_pc    = head_s.pc;
        end else if (bypass_s) begin
            fq_valid = 1'b1;
            fq_ir    = q_imem;
            fq_pc    = fetch_pc_r;
        end else begin
            fq_valid = 1'b0;
            fq_ir    = NOP_IR;
            fq_pc    = {PC_W{1'b0}};
        end
        pop_s  = fq_valid & ~stall & ~redirect;
        push_s = ~redirect & ((count_r < FQ_CNT_W'(FQ_DEPTH)) | pop_s);
        // A bypassed word that decode takes this cycle never enters storage,
        // and with an empty queue there is nothing stored to dequeue.
        store_s = push_s & ~(bypass_s & pop_s);
        deq_s   = pop_s & ~bypass_s;
    end

    // Fetch PC, pointers and occupancy; redirect overrides everything else.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_r <= {PC_W{1'b0}};
            count_r    <= {FQ_CNT_W{1'b0}};
            rd_ptr_r   <= {FQ_PTR_W{1'b0}};
            wr_ptr_r   <= {FQ_PTR_W{1'b0}};
        end else if (redirect) begin
            fetch_pc_r <= redirect_pc;
            count_r    <= {FQ_CNT_W{1'b0}};
            rd_ptr_r   <= {FQ_PTR_W{1'b0}};
            wr_ptr_r   <= {FQ_PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd1;
            end
            if (store_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (deq_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({store_s, deq_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign address_imem = fetch_pc_r;
    assign fq_count     = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a cycle-by-cycle vector table
// (inputs plus expected outputs) followed by an asynchronous reset sequence.
// imem is modelled as a fixed function of the address.
module tb_fetch_queue;

    logic        clock;
    logic        reset;
    logic [31:0] address_imem;
    logic [31:0] q_imem;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        fq_valid;
    logic [31:0] fq_ir;
    logic [31:0] fq_pc;
    logic [2:0]  fq_count;

    int n_checks;
    int n_errors;

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        stall;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs [26];
    int   n_vec;

    fetch_queue dut (
        .clock        (clock),
        .reset        (reset),
        .address_imem (address_imem),
        .q_imem       (q_imem),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .stall        (stall),
        .fq_valid     (fq_valid),
        .fq_ir        (fq_ir),
        .fq_pc        (fq_pc),
        .fq_count     (fq_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h2840_0005;
        return a + 32'h1000_0000;
    endfunction

    always_comb q_imem = imem_word(address_imem);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] addr, input logic valid,
                           input logic [31:0] pc, input logic [2:0] cnt);
        logic [31:0] exp_ir;
        logic [31:0] exp_pc;
        exp_ir = valid ? imem_word(pc) : 32'd0;
        exp_pc = valid ? pc : 32'd0;
        chk({tag, " address_imem"}, address_imem, addr);
        chk({tag, " fq_valid"}, {31'd0, fq_valid}, {31'd0, valid});
        chk({tag, " fq_ir"}, fq_ir, exp_ir);
        chk({tag, " fq_pc"}, fq_pc, exp_pc);
        chk({tag, " fq_count"}, {29'd0, fq_count}, {29'd0, cnt});
    endtask

    function automatic vec_t mk(input logic r, input logic [31:0] rpc, input logic s,
                                input logic [31:0] addr, input logic v,
                                input logic [31:0] pc, input logic [2:0] cnt);
        vec_t t;
        t.redirect = r; t.rpc = rpc; t.stall = s;
        t.addr = addr; t.valid = v; t.pc = pc; t.cnt = cnt;
        return t;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
        n_vec = 9;
        vecs[0] = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h0,  3'd0);
        vecs[1] = mk(1'b0, 32'h0,  1'b0, 32'h1,  1'b1, 32'h1,  3'd0);
        vecs[2] = mk(1'b0, 32'h0,  1'b1, 32'h2,  1'b1, 32'h2,  3'd0);
        vecs[3] = mk(1'b0, 32'h0,  1'b1, 32'h3,  1'b1, 32'h2,  3'd1);
        vecs[4] = mk(1'b0, 32'h0,  1'b0, 32'h4,  1'b1, 32'h2,  3'd2);
        vecs[5] = mk(1'b0, 32'h0,  1'b0, 32'h5,  1'b1, 32'h3,  3'd2);
        vecs[6] = mk(1'b1, 32'h40, 1'b0, 32'h6,  1'b1, 32'h4,  3'd2);
        vecs[7] = mk(1'b1, 32'h80, 1'b0, 32'h40, 1'b0, 32'h0,  3'd0);
        vecs[8] = mk(1'b0, 32'h0,  1'b0, 32'h80, 1'b1, 32'h80, 3'd0);
`else
        n_vec = 26;
        vecs[0]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        3'd0);
        vecs[1]  = mk(1'b0, 32'h0,        1'b0, 32'h1,        1'b1, 32'h0,        3'd1);
        vecs[2]  = mk(1'b0, 32'h0,        1'b0, 32'h2,        1'b1, 32'h1,        3'd1);
        vecs[3]  = mk(1'b0, 32'h0,        1'b1, 32'h3,        1'b1, 32'h2,        3'd1);
        vecs[4]  = mk(1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h2,        3'd2);
        vecs[5]  = mk(1'b0, 32'h0,        1'b1, 32'h5,        1'b1, 32'h2,        3'd3);
        vecs[6]  = mk(1'b0, 32'h0,        1'b1, 32'h6,        1'b1, 32'h2,        3'd4);
        vecs[7]  = mk(1'b0, 32'h0,        1'b1, 32'h6,        1'b1, 32'h2,        3'd4);
        vecs[8]  = mk(1'b0, 32'h0,        1'b0, 32'h6,        1'b1, 32'h2,        3'd4);
        vecs[9]  = mk(1'b0, 32'h0,        1'b0, 32'h7,        1'b1, 32'h3,        3'd4);
        vecs[10] = mk(1'b0, 32'h0,        1'b0, 32'h8,        1'b1, 32'h4,        3'd4);
        vecs[11] = mk(1'b0, 32'h0,        1'b0, 32'h9,        1'b1, 32'h5,        3'd4);
        vecs[12] = mk(1'b0, 32'h0,        1'b0, 32'hA,        1'b1, 32'h6,        3'd4);
        vecs[13] = mk(1'b1, 32'h40,       1'b1, 32'hB,        1'b1, 32'h7,        3'd4);
        vecs[14] = mk(1'b0, 32'h0,        1'b1, 32'h40,       1'b0, 32'h0,        3'd0);
        vecs[15] = mk(1'b0, 32'h0,        1'b1, 32'h41,       1'b1, 32'h40,       3'd1);
        vecs[16] = mk(1'b0, 32'h0,        1'b1, 32'h42,       1'b1, 32'h40,       3'd2);
        vecs[17] = mk(1'b1, 32'h40,       1'b0, 32'h43,       1'b1, 32'h40,       3'd3);
        vecs[18] = mk(1'b0, 32'h0,        1'b0, 32'h40,       1'b0, 32'h0,        3'd0);
        vecs[19] = mk(1'b0, 32'h0,        1'b0, 32'h41,       1'b1, 32'h40,       3'd1);
        vecs[20] = mk(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h42,      1'b1, 32'h41,       3'd1);
        vecs[21] = mk(1'b0, 32'h0,        1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0,       3'd0);
        vecs[22] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hFFFF_FFFF, 3'd1);
        vecs[23] = mk(1'b1, 32'h100,      1'b1, 32'h1,        1'b1, 32'h0,        3'd1);
        vecs[24] = mk(1'b0, 32'h0,        1'b1, 32'h100,      1'b0, 32'h0,        3'd0);
        vecs[25] = mk(1'b0, 32'h0,        1'b1, 32'h101,      1'b1, 32'h100,      3'd1);
`endif

        // Reset state.
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        stall       = 1'b0;
        #12;
        chk_all("reset", 32'd0, 1'b0, 32'd0, 3'd0);
        reset = 1'b0;

        // Vector table: drive, let settle, compare, then take the edge.
        for (int i = 0; i < n_vec; i++) begin
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            stall       = vecs[i].stall;
            #1;
            chk_all($sformatf("v%0d", i), vecs[i].addr, vecs[i].valid, vecs[i].pc, vecs[i].cnt);
            @(posedge clock);
            #1;
        end

`ifndef FETCH_QUEUE_BYPASS_EN
        // Asynchronous reset mid-cycle with two entries queued.
        redirect = 1'b0;
        stall    = 1'b1;
        #1;
        chk_all("pre_areset", 32'h102, 1'b1, 32'h100, 3'd2);
        #1;
        reset = 1'b1;
        #1;
        chk_all("areset_now", 32'd0, 1'b0, 32'd0, 3'd0);
        @(posedge clock);
        #1;
        chk_all("areset_held", 32'd0, 1'b0, 32'd0, 3'd0);
        @(negedge clock);
        reset = 1'b0;
        stall = 1'b0;
        #1;
        chk_all("post_reset0", 32'd0, 1'b0, 32'd0, 3'd0);
        @(posedge clock);
        #1;
        chk_all("post_reset1", 32'd1, 1'b1, 32'd0, 3'd1);
        @(posedge clock);
        #1;
        chk_all("post_reset2", 32'd2, 1'b1, 32'd1, 3'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 SHALL have port: clock  in  1  master clock; all state changes on the rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: address_imem  out  32  fetch PC presented to imem.
REQ-005 SHALL have port: q_imem  in  32  instruction word for address_imem, valid in the same cycle.
REQ-006 SHALL have port: redirect  in  1  branch/jump taken; flush the queue and restart fetch.
REQ-007 SHALL have port: redirect_pc  in  32  new fetch PC, sampled when redirect=1.
REQ-008 SHALL have port: stall  in  1  decode not accepting; the head is held.
REQ-009 SHALL have port: fq_valid  out  1  head entry present.
REQ-010 SHALL have port: fq_ir  out  32  head instruction, or 32'b0 (nop) when fq_valid=0.
REQ-011 SHALL have port: fq_pc  out  32  PC of the head instruction, or 0 when fq_valid=0.
REQ-012 SHALL have port: fq_count  out  3  occupancy, 0..4.

Function
REQ-013 The queue SHALL be a 4-entry circular FIFO; each entry holds {pc[31:0], ir[31:0]}.
REQ-014 address_imem SHALL equal the internal fetch_pc register.
REQ-015 pop SHALL be fq_valid & ~stall & ~redirect.
REQ-016 push SHALL be ~redirect & (fq_count<4 | pop); the pushed entry is {fetch_pc, q_imem}.
REQ-017 On push, fetch_pc SHALL increment by 1 (word addressing), wrapping modulo 2^32.
REQ-018 With no push, fetch_pc SHALL hold.
REQ-019 Simultaneous push and pop SHALL leave fq_count unchanged, including when full.
REQ-020 Read and write pointers SHALL be 2 bits and wrap from 3 to 0.
REQ-021 On redirect, the next state SHALL be: count=0, pointers=0, fetch_pc=redirect_pc; no push or pop occurs in that cycle.
REQ-022 redirect SHALL take priority over stall, push and pop.
REQ-023 fq_valid SHALL equal (fq_count!=0); fq_ir and fq_pc are combinational from the head entry.
REQ-024 Latency SHALL be one cycle: an instruction fetched in cycle N appears at the head no earlier than cycle N+1.
REQ-025 With stall held, the queue SHALL fill to 4 and then stop fetching, with address_imem constant.

Reset
REQ-026 Reset SHALL take effect immediately and asynchronously: fetch_pc=0, count=0, pointers=0, fq_valid=0, fq_ir=0, fq_pc=0.
REQ-027 Entry storage SHALL not require reset.
REQ-028 Reset asserted mid-operation SHALL discard all entries and any pending redirect.
REQ-029 Fetch SHALL resume at PC 0 in the first cycle after reset deasserts.

Configuration
REQ-030 Macro FETCH_QUEUE_BYPASS_EN SHALL be the single configuration option.
REQ-031 When FETCH_QUEUE_BYPASS_EN is defined and count=0 and ~redirect: fq_valid=1, fq_ir=q_imem, fq_pc=fetch_pc in the same cycle (zero latency); if popped, the word is not stored; fetch_pc still increments.
REQ-032 When FETCH_QUEUE_BYPASS_EN is undefined, the behaviour SHALL be exactly per REQ-023/REQ-024.

Structure
REQ-033 Shared package fetch_pkg SHALL hold FQ_DEPTH=4, FQ_PTR_W=2, FQ_CNT_W=3, NOP_IR=32'b0 and the PC width 32.
REQ-034 One sub-module, fq_entry_array, SHALL hold the 4x64-bit storage: one write port with write enable, one combinational read port, no reset.
REQ-035 Pointer, count and fetch_pc logic SHALL reside in fetch_queue.

Verification
REQ-036 Reset, then run 3 cycles with stall=0: the bench SHALL see address_imem 0,1,2 and fq_pc 0,1 in cycles 1 and 2 (bypass off).
REQ-037 Hold stall=1 for 6 cycles from reset: the bench SHALL see fq_count reach 4, address_imem freeze at 4, and fq_pc hold at 0.
REQ-038 Queue full with stall=0: the bench SHALL see push and pop in the same cycle, fq_count stay at 4, and pointers wrap 3->0 with pc order preserved.
REQ-039 Redirect with redirect_pc=0x40 while fq_count=3: the next cycle the bench SHALL see fq_valid=0, fq_ir=0, address_imem=0x40; the cycle after, fq_pc=0x40.
REQ-040 Assert reset asynchronously mid-cycle with fq_count=2: the bench SHALL see outputs zero immediately and fetch restart at 0.
REQ-041 With FETCH_QUEUE_BYPASS_EN defined and q_imem=0x28400005 at pc 0 after reset: the bench SHALL see fq_valid=1 and fq_ir=0x28400005 in the same cycle, with fq_count=0.
